// File: rtl/gyro_tilt_sampler.sv
// rtl/gyro_tilt_sampler.sv - decimating box-average tilt sampler with change interrupt
module gyro_tilt_sampler #(
  parameter int CLK_DIV  = 100000,
  parameter int AVG_LOG2 = 3,
  parameter int DEADBAND = 16
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic signed [15:0] X,
  input  logic signed [15:0] Y,
  input  logic signed [15:0] Z,
  input  logic        [1:0]  ADDR,
  output logic        [31:0] RD_DATA,
  output logic               INTR,
  input  logic               INTR_ACK
);

  localparam int CW = $clog2(CLK_DIV);
  localparam int AW = 16 + AVG_LOG2;
  // AVG_LOG2 = 0 still needs a 1-bit sample counter; it simply stays at 0.
  localparam int SW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0] TICK_LAST = CW'(CLK_DIV - 1);
  localparam logic [SW-1:0] SCNT_LAST = SW'((1 << AVG_LOG2) - 1);
  localparam logic [16:0]   DB        = 17'(DEADBAND);

  typedef enum logic [1:0] {ACCUM, DIVIDE, COMPARE} state_t;

  state_t state, state_next;

  logic [CW-1:0] tick_cnt;
  logic          tick;
  logic [SW-1:0] scnt;
  logic          scnt_full;
  logic          acc_en, div_en, cmp_en;
  logic          over;

  logic signed [AW-1:0] acc_x, acc_y, acc_z;
  logic signed [15:0]   new_x, new_y, new_z;
  logic signed [15:0]   avg_x, avg_y, avg_z;
  logic        [7:0]    seq;
  logic                 intr;

  // |a - b| evaluated at 17 bits so full-scale swings cannot overflow
  function automatic logic [16:0] abs_diff(input logic signed [15:0] a,
                                           input logic signed [15:0] b);
    logic signed [16:0] d;
    d = 17'(a) - 17'(b);
    return d[16] ? 17'(-d) : 17'(d);
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign scnt_full = (scnt == SCNT_LAST);
  assign over      = (abs_diff(new_x, avg_x) > DB) ||
                     (abs_diff(new_y, avg_y) > DB) ||
                     (abs_diff(new_z, avg_z) > DB);

  // Free-running sample-rate divider; never stalls
  always_ff @(posedge CLK) begin
    if (RST)       tick_cnt <= '0;
    else if (tick) tick_cnt <= '0;
    else           tick_cnt <= tick_cnt + 1'b1;
  end

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RST) state <= ACCUM;
    else     state <= state_next;
  end

  // Next-state and datapath strobes
  always_comb begin
    state_next = state;
    acc_en     = 1'b0;
    div_en     = 1'b0;
    cmp_en     = 1'b0;
    case (state)
      ACCUM: begin
        if (tick) begin
          acc_en = 1'b1;
          if (scnt_full) state_next = DIVIDE;
        end
      end
      DIVIDE: begin
        div_en     = 1'b1;
        state_next = COMPARE;
      end
      COMPARE: begin
        cmp_en     = 1'b1;
        state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // Accumulate, divide by window size, publish all axes and SEQ together
  always_ff @(posedge CLK) begin
    if (RST) begin
      acc_x <= '0; acc_y <= '0; acc_z <= '0;
      new_x <= '0; new_y <= '0; new_z <= '0;
      avg_x <= '0; avg_y <= '0; avg_z <= '0;
      scnt  <= '0;
      seq   <= '0;
    end else begin
      if (acc_en) begin
        acc_x <= acc_x + AW'(X);
        acc_y <= acc_y + AW'(Y);
        acc_z <= acc_z + AW'(Z);
        scnt  <= scnt_full ? '0 : scnt + 1'b1;
      end
      if (div_en) begin
        new_x <= 16'(acc_x >>> AVG_LOG2);
        new_y <= 16'(acc_y >>> AVG_LOG2);
        new_z <= 16'(acc_z >>> AVG_LOG2);
        acc_x <= '0; acc_y <= '0; acc_z <= '0;
        scnt  <= '0;
      end
      if (cmp_en) begin
        avg_x <= new_x;
        avg_y <= new_y;
        avg_z <= new_z;
        seq   <= seq + 1'b1;
      end
    end
  end

  // Level interrupt; a new set in COMPARE beats a simultaneous acknowledge
  always_ff @(posedge CLK) begin
    if (RST)                 intr <= 1'b0;
    else if (cmp_en && over) intr <= 1'b1;
    else if (INTR_ACK)       intr <= 1'b0;
  end

  assign INTR = intr;

  // Read port: combinational select of registered state
  always_comb begin
    RD_DATA = '0;
    case (ADDR)
      2'd0: RD_DATA = {{16{avg_x[15]}}, avg_x};
      2'd1: RD_DATA = {{16{avg_y[15]}}, avg_y};
      2'd2: RD_DATA = {{16{avg_z[15]}}, avg_z};
      2'd3: RD_DATA = {15'b0, seq, 8'b0, intr};
      default: RD_DATA = '0;
    endcase
  end

endmodule

// File: tb/tb_gyro_tilt_sampler.sv
// tb/tb_gyro_tilt_sampler.sv - directed table-driven bench for gyro_tilt_sampler
module tb_gyro_tilt_sampler;

  logic               CLK = 1'b0;
  logic               RST = 1'b1;
  logic signed [15:0] X = '0, Y = '0, Z = '0;
  logic        [1:0]  ADDR = '0;
  logic        [31:0] RD_DATA;
  logic               INTR;
  logic               INTR_ACK = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  gyro_tilt_sampler #(.CLK_DIV(4), .AVG_LOG2(2), .DEADBAND(16)) dut (
    .CLK(CLK), .RST(RST), .X(X), .Y(Y), .Z(Z),
    .ADDR(ADDR), .RD_DATA(RD_DATA), .INTR(INTR), .INTR_ACK(INTR_ACK)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] xs [4];
    logic [15:0] y;
    logic [15:0] z;
    int          ex, ey, ez, eseq;
    bit          eintr;
    bit          ack_cmp;
    bit          ack_after;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add(input logic [15:0] x0, x1, x2, x3, y, z,
                     input int ex, ey, ez, eseq,
                     input bit eintr, ack_cmp, ack_after);
    vec_t v;
    v.xs[0] = x0; v.xs[1] = x1; v.xs[2] = x2; v.xs[3] = x3;
    v.y = y; v.z = z;
    v.ex = ex; v.ey = ey; v.ez = ez; v.eseq = eseq;
    v.eintr = eintr; v.ack_cmp = ack_cmp; v.ack_after = ack_after;
    vecs.push_back(v);
  endtask

  task automatic check_pub(input string tag, input int ex, ey, ez, eseq, input bit eintr);
    logic [31:0] exp;
    logic [7:0]  s;
    s = 8'(eseq);
    for (int a = 0; a < 4; a++) begin
      ADDR = 2'(a);
      #1;
      case (a)
        0: exp = 32'(ex);
        1: exp = 32'(ey);
        2: exp = 32'(ez);
        default: exp = {15'b0, s, 8'b0, eintr};
      endcase
      chk($sformatf("%s_rd%0d", tag, a), RD_DATA, exp);
    end
    chk({tag, "_intr"}, {31'b0, INTR}, {31'b0, eintr});
  endtask

  task automatic check_zero(input string tag);
    for (int a = 0; a < 4; a++) begin
      ADDR = 2'(a);
      #1;
      chk($sformatf("%s_rd%0d", tag, a), RD_DATA, 32'h0);
    end
    chk({tag, "_intr"}, {31'b0, INTR}, 32'h0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    check_zero("after_rst");
  endtask

  // One sample period: inputs presented right after a tick edge, taken at the next tick
  task automatic samp(input logic [15:0] x, y, z, input bit chk0);
    X = x; Y = y; Z = z;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLK); #1;
      if (chk0) begin
        ADDR = 2'd0; #1; chk("pre_pub_x", RD_DATA, 32'h0);
        ADDR = 2'd3; #1; chk("pre_pub_st", RD_DATA, 32'h0);
      end
    end
  endtask

  initial begin
    int n;
    //   x0        x1        x2        x3        y         z         ex     ey      ez   seq intr cmp aft
    add(16'd100,  16'd100,  16'd100,  16'd100,  16'hFFD8, 16'h0000, 100,   -40,    0,   1,  1,  0,  1);
    add(16'd100,  16'd100,  16'd100,  16'd100,  16'hFFD8, 16'h0000, 100,   -40,    0,   2,  0,  0,  0);
    add(16'hFFFF, 16'hFFFE, 16'hFFFD, 16'hFFFB, 16'hFFD8, 16'h0000, -3,    -40,    0,   3,  1,  0,  1);
    add(16'd1,    16'd2,    16'd3,    16'd5,    16'hFFD8, 16'h0000, 2,     -40,    0,   4,  0,  0,  0);
    add(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h0000, 32767, -32768, 0,   5,  1,  0,  1);
    add(16'd100,  16'd100,  16'd100,  16'd100,  16'h0000, 16'h0000, 100,   0,      0,   6,  1,  0,  1);
    add(16'd110,  16'd120,  16'd114,  16'd120,  16'h0000, 16'h0000, 116,   0,      0,   7,  0,  0,  0);
    add(16'd100,  16'd100,  16'd100,  16'd100,  16'h0000, 16'h0000, 100,   0,      0,   8,  0,  0,  0);
    add(16'd117,  16'd117,  16'd118,  16'd116,  16'h0000, 16'h0000, 117,   0,      0,   9,  1,  0,  1);
    add(16'd100,  16'd100,  16'd100,  16'd100,  16'h0000, 16'h0000, 100,   0,      0,   10, 1,  0,  1);
    add(16'd83,   16'd83,   16'd83,   16'd83,   16'h0000, 16'h0000, 83,    0,      0,   11, 1,  1,  1);
    add(16'd80,   16'd84,   16'd85,   16'd83,   16'h0000, 16'h0000, 83,    0,      0,   12, 0,  0,  0);
    add(16'd83,   16'd83,   16'd83,   16'd83,   16'h0000, 16'hFFEC, 83,    0,      -20, 13, 1,  0,  0);
    add(16'd83,   16'd83,   16'd83,   16'd83,   16'h0000, 16'hFFEC, 83,    0,      -20, 14, 0,  1,  0);
    n = vecs.size();

    // Reset state while RST is still held
    repeat (2) @(posedge CLK);
    #1;
    check_zero("in_rst");
    RST = 1'b0;

    // Table: each window's result is checked during the first sample of the next one
    for (int w = 0; w <= n; w++) begin
      for (int i = 0; i < 4; i++) begin
        if (w < n) begin
          X = vecs[w].xs[i]; Y = vecs[w].y; Z = vecs[w].z;
        end
        for (int c = 0; c < 4; c++) begin
          @(posedge CLK); #1;
          if (w == 0) begin
            ADDR = 2'(c); #1;
            chk("first_win_zero", RD_DATA, 32'h0);
            chk("first_win_intr", {31'b0, INTR}, 32'h0);
          end
          if (w > 0 && i == 0) begin
            if (c == 0 && vecs[w-1].ack_cmp) INTR_ACK = 1'b1;
            if (c == 1) begin
              INTR_ACK = 1'b0;
              check_pub($sformatf("win%0d", w - 1), vecs[w-1].ex, vecs[w-1].ey,
                        vecs[w-1].ez, vecs[w-1].eseq, vecs[w-1].eintr);
              if (vecs[w-1].ack_after) INTR_ACK = 1'b1;
            end
            if (c == 2 && vecs[w-1].ack_after) begin
              INTR_ACK = 1'b0;
              chk($sformatf("win%0d_ack_clr", w - 1), {31'b0, INTR}, 32'h0);
            end
          end
        end
        if (w == n) break;
      end
    end

    // Mid-window reset with an interrupt pending
    do_reset();
    for (int i = 0; i < 4; i++) samp(16'd100, 16'd0, 16'd0, 1'b0);
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    check_pub("pre_rst_win", 100, 0, 0, 1, 1'b1);
    @(posedge CLK); #1;
    X = 16'd500;
    @(posedge CLK); #1;
    samp(16'd500, 16'd0, 16'd0, 1'b0);
    do_reset();
    samp(16'd40, 16'hFFF8, 16'd4, 1'b1);
    samp(16'd41, 16'hFFF8, 16'd4, 1'b1);
    samp(16'd42, 16'hFFF8, 16'd4, 1'b1);
    samp(16'd43, 16'hFFF8, 16'd4, 1'b1);
    @(posedge CLK); #1;
    check_zero("divide_cyc");
    @(posedge CLK); #1;
    check_pub("post_rst_win", 41, -8, 4, 1, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
